fetch_queue: RTL and testbench

Instruction fetch queue between the IF stage and the ID stage of the 5-stage RISC-V pipeline. Captures each {PC, instruction} pair returned by InstMem and buffers it in a DEPTH-entry circular FIFO. Presents the oldest entry to decode under a valid/ready handshake. Discards all buffered wrong-path entries on a taken branch and raises full so the PC stage holds its fetch address.

---
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 81 ++++++++
 tb/tb_fetch_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and decode.
// The master side is the fetch/decode/EX context; the slave side is the queue itself.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

interface fetch_queue_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH
);
  logic                         push_valid;
  logic [ADDR_WIDTH-1:0]        push_pc;
  logic [31:0]                  push_inst;
  logic                         full;
  logic                         pop_ready;
  logic                         pop_valid;
  logic [ADDR_WIDTH-1:0]        pop_pc;
  logic [31:0]                  pop_inst;
  logic                         flush;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  modport master (
    output push_valid, push_pc, push_inst, pop_ready, flush,
    input  full, pop_valid, pop_pc, pop_inst, count, overflow
  );

  modport slave (
    input  push_valid, push_pc, push_inst, pop_ready, flush,
    output full, pop_valid, pop_pc, pop_inst, count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular {PC, instruction} FIFO between IF and ID; flush discards wrong-path
// entries on a taken branch, and full doubles as the PC-stage fetch stall.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter int          ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]           inst_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;

  logic is_full;
  logic is_valid;
  logic pop_fire;
  logic push_ok;
  logic push_drop;

  assign is_full   = (count_q == CNT_W'(DEPTH));
  assign is_valid  = (count_q != '0);
  assign pop_fire  = is_valid & q.pop_ready;
  assign push_ok   = q.push_valid & (~is_full | pop_fire);
  assign push_drop = q.push_valid & is_full & ~pop_fire;

  // Storage needs no reset; visibility is governed entirely by count and rd_ptr.
  always_ff @(posedge clk) begin
    if (!rst && !q.flush && push_ok) begin
      pc_mem[wr_ptr]   <= q.push_pc;
      inst_mem[wr_ptr] <= q.push_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop_fire) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_fire && !push_ok) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Outputs depend only on registered state, so decode sees a stable head all cycle.
  assign q.full      = is_full;
  assign q.pop_valid = is_valid;
  assign q.count     = count_q;
  assign q.overflow  = overflow_q;
  assign q.pop_pc    = is_valid ? pc_mem[rd_ptr]   : '0;
  assign q.pop_inst  = is_valid ? inst_mem[rd_ptr] : NOP_INST;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue, compared against a queue-based
// model of the occupancy, ordering, flush and overflow rules.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          AW    = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  logic [31:0] m_pc   [$];
  logic [31:0] m_inst [$];
  logic        m_overflow = 1'b0;

  logic [31:0] got_pc [$];

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .q   (fq.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic compareAll();
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    e_pc   = (m_pc.size() != 0) ? m_pc[0]   : 32'h0;
    e_inst = (m_pc.size() != 0) ? m_inst[0] : NOP;
    checkOutput({phase, "_pop_valid"}, 64'(fq.pop_valid), 64'(m_pc.size() != 0));
    checkOutput({phase, "_pop_pc"},    64'(fq.pop_pc),    64'(e_pc));
    checkOutput({phase, "_pop_inst"},  64'(fq.pop_inst),  64'(e_inst));
    checkOutput({phase, "_count"},     64'(fq.count),     64'(m_pc.size()));
    checkOutput({phase, "_full"},      64'(fq.full),      64'(m_pc.size() == DEPTH));
    checkOutput({phase, "_overflow"},  64'(fq.overflow),  64'(m_overflow));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                               input logic pr, input logic fl, input logic r);
    bit pop_fire;
    bit push_ok;
    fq.push_valid = pv;
    fq.push_pc    = pc;
    fq.push_inst  = inst;
    fq.pop_ready  = pr;
    fq.flush      = fl;
    rst           = r;
    #2;
    if (fq.pop_valid && pr) got_pc.push_back(fq.pop_pc);
    @(posedge clk);
    if (r) begin
      m_pc.delete();
      m_inst.delete();
      m_overflow = 1'b0;
    end else if (fl) begin
      m_pc.delete();
      m_inst.delete();
    end else begin
      pop_fire = (m_pc.size() != 0) && pr;
      push_ok  = pv && ((m_pc.size() < DEPTH) || pop_fire);
      if (pv && !push_ok) m_overflow = 1'b1;
      if (pop_fire) begin
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (push_ok) begin
        m_pc.push_back(pc);
        m_inst.push_back(inst);
      end
    end
    #1;
    compareAll();
  endtask

  task automatic idle(input logic pr);
    applyStimulus(1'b0, 32'h0, 32'h0, pr, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pr);
    applyStimulus(1'b1, pc, inst, pr, 1'b0, 1'b0);
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic fillFour();
    for (int i = 0; i < 4; i++) push(32'(4 * i), 32'h11 + 32'(i), 1'b0);
  endtask

  initial begin
    fq.push_valid = 1'b0;
    fq.push_pc    = '0;
    fq.push_inst  = '0;
    fq.pop_ready  = 1'b0;
    fq.flush      = 1'b0;

    phase = "reset";
    doReset(2);
    checkOutput("reset_pop_inst_nop", 64'(fq.pop_inst), 64'(32'h13));

    phase = "fill";
    fillFour();
    checkOutput("fill_full", 64'(fq.full), 64'd1);
    checkOutput("fill_head_pc", 64'(fq.pop_pc), 64'h0);
    checkOutput("fill_head_inst", 64'(fq.pop_inst), 64'h11);

    phase = "overflow";
    push(32'h10, 32'h15, 1'b0);
    checkOutput("overflow_set", 64'(fq.overflow), 64'd1);
    got_pc.delete();
    for (int i = 0; i < 5; i++) idle(1'b1);
    checkOutput("overflow_drain_len", 64'(got_pc.size()), 64'd4);
    for (int i = 0; i < got_pc.size(); i++)
      checkOutput("overflow_drain_pc", 64'(got_pc[i]), 64'(32'(4 * i)));

    phase = "passthru";
    doReset(1);
    fillFour();
    push(32'h10, 32'h15, 1'b1);
    checkOutput("passthru_head", 64'(fq.pop_pc), 64'h4);
    checkOutput("passthru_no_overflow", 64'(fq.overflow), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    phase = "wrap";
    doReset(1);
    got_pc.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        idle(1'b0);
        idle(1'b0);
      end
      push(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), (i != 4) && (i != 5));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    checkOutput("wrap_pop_len", 64'(got_pc.size()), 64'd10);
    for (int i = 0; i < got_pc.size(); i++)
      checkOutput("wrap_pop_pc", 64'(got_pc[i]), 64'(32'h100 + 32'(4 * i)));

    phase = "flush";
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(4 * i), 32'h50 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'h200, 32'h77, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_count", 64'(fq.count), 64'd0);
    checkOutput("flush_inst_nop", 64'(fq.pop_inst), 64'(32'h13));
    push(32'h300, 32'h88, 1'b0);
    checkOutput("flush_target_head", 64'(fq.pop_pc), 64'h300);
    idle(1'b1);

    phase = "empty_pop";
    for (int i = 0; i < 3; i++) idle(1'b1);
    push(32'h400, 32'h99, 1'b0);
    checkOutput("empty_pop_next_head", 64'(fq.pop_pc), 64'h400);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    $urandom & 32'hFFFF_FFFC,
                    $urandom,
                    $urandom_range(0, 9) < 5,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
